regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port (add_C/data_C/write_enable) between two writeback sources:

---
 rtl/regfile_wb_arbiter_pkg.sv | 18 +
 rtl/regfile_wb_arbiter_fifo.sv | 51 +++++
 rtl/regfile_wb_arbiter.sv | 146 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, writeback request record and arbiter state encoding for the
// register-file writeback arbiter.
package regfile_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        PIPE  = 1'b0,
        FORCE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// Small synchronous FIFO buffering mul/div writeback requests.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign o_rdata   = r_mem[r_rd_ptr[PTR_W-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // NOTE: the storage array is deliberately not reset; the pointers alone decide
    // which entries are valid, so clearing the data would only cost reset fanout.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between the pipeline WB stage
// (priority) and buffered mul/div results, and tracks in-flight mul/div destinations.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb0_valid,
    input  logic [ADDR_W-1:0] wb0_addr,
    input  logic [DATA_W-1:0] wb0_data,
    output logic              wb0_ready,
    input  logic              wb1_valid,
    input  logic [ADDR_W-1:0] wb1_addr,
    input  logic [DATA_W-1:0] wb1_data,
    output logic              wb1_ready,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_set_addr,
    input  logic [ADDR_W-1:0] chk_addr_a,
    input  logic [ADDR_W-1:0] chk_addr_b,
    output logic              raw_stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data
);

    localparam int NREG  = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

    wb_req_t           w_push_req;
    wb_req_t           w_head;
    wb_req_t           w_win;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_grant0;
    logic              w_commit;
    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic [CNT_W-1:0]  w_starve_next;
    logic              r_rf_we;
    logic              r_rf_src1;
    logic [ADDR_W-1:0] r_rf_addr;
    logic [DATA_W-1:0] r_rf_data;
    logic [NREG-1:0]   r_pend;

    assign w_push_req = {wb1_addr, wb1_data};
    assign w_push     = wb1_valid && !w_fifo_full;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(wb_req_t))
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_push_req),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // NOTE: every signal driven here gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        w_grant0      = 1'b0;
        w_pop         = 1'b0;
        w_state_next  = r_state;
        w_starve_next = r_starve_cnt;
        w_win         = w_head;

        case (r_state)
            PIPE: begin
                if (wb0_valid)          w_grant0 = 1'b1;
                else if (!w_fifo_empty) w_pop    = 1'b1;
            end
            FORCE:   w_pop = !w_fifo_empty;
            default: w_pop = 1'b0;
        endcase

        // A waiting head that loses its STARVE_LIMIT-th cycle forces the next grant.
        if (w_pop) begin
            w_starve_next = '0;
            w_state_next  = PIPE;
        end else if (!w_fifo_empty) begin
            w_starve_next = r_starve_cnt + CNT_ONE;
            if (r_starve_cnt == CNT_LAST) w_state_next = FORCE;
        end

        if (w_grant0) begin
            w_win.addr = wb0_addr;
            w_win.data = wb0_data;
        end
    end

    assign w_commit = (w_grant0 || w_pop) && (w_win.addr != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= PIPE;
            r_starve_cnt <= '0;
            r_rf_we      <= 1'b0;
            r_rf_src1    <= 1'b0;
            r_rf_addr    <= '0;
            r_rf_data    <= '0;
        end else begin
            r_state      <= w_state_next;
            r_starve_cnt <= w_starve_next;
            r_rf_we      <= w_commit;
            r_rf_src1    <= w_pop;
            if (w_commit) begin
                r_rf_addr <= w_win.addr;
                r_rf_data <= w_win.data;
            end
        end
    end

    // Pending bits clear only once the mul/div write is actually presented to the
    // register file, since decode has no bypass from the write port.
    // NOTE: both updates are non-blocking to the same vector, so the later set
    // overrides an earlier clear of the same register in one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            if (r_rf_we && r_rf_src1)         r_pend[r_rf_addr]   <= 1'b0;
            if (sb_set && sb_set_addr != '0) r_pend[sb_set_addr] <= 1'b1;
        end
    end

    assign raw_stall = ((chk_addr_a != '0) && r_pend[chk_addr_a]) ||
                       ((chk_addr_b != '0) && r_pend[chk_addr_b]);
    assign wb0_ready = w_grant0;
    assign wb1_ready = !w_fifo_full;
    assign rf_we     = r_rf_we;
    assign rf_addr   = r_rf_addr;
    assign rf_data   = r_rf_data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a randomized
// run against a queue-based reference model and a mirrored register file.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;
    localparam int NREG  = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              wb0_valid, wb1_valid, sb_set;
    logic [ADDR_W-1:0] wb0_addr, wb1_addr, sb_set_addr, chk_addr_a, chk_addr_b;
    logic [DATA_W-1:0] wb0_data, wb1_data;
    logic              wb0_ready, wb1_ready, raw_stall, rf_we;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
        .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
        .sb_set(sb_set), .sb_set_addr(sb_set_addr),
        .chk_addr_a(chk_addr_a), .chk_addr_b(chk_addr_b), .raw_stall(raw_stall),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data)
    );

    // Register file as seen through the write port.
    logic [DATA_W-1:0] dut_regs [NREG];
    always @(posedge clk) if (rf_we) dut_regs[rf_addr] <= rf_data;

    // Reference model: queue of buffered requests, loss counter, pending flags.
    wb_req_t           m_q[$];
    bit                m_force;
    int                m_lose;
    bit                m_pend [NREG];
    bit                m_rf_we, m_rf_from_q;
    logic [ADDR_W-1:0] m_rf_addr;
    logic [DATA_W-1:0] m_rf_data;
    logic [DATA_W-1:0] m_regs [NREG];
    bit                e_wb0_ready, e_wb1_ready, e_raw, e_pop, e_win_valid;
    wb_req_t           e_win;

    function automatic void model_reset();
        m_q.delete();
        m_force = 0; m_lose = 0;
        foreach (m_pend[i]) m_pend[i] = 0;
        m_rf_we = 0; m_rf_from_q = 0; m_rf_addr = '0; m_rf_data = '0;
    endfunction

    function automatic void model_comb();
        e_wb1_ready = (m_q.size() < DEPTH);
        e_wb0_ready = 0; e_pop = 0; e_win_valid = 0; e_win = '0;
        if (!m_force && wb0_valid) begin
            e_wb0_ready = 1; e_win_valid = 1;
            e_win.addr = wb0_addr; e_win.data = wb0_data;
        end else if (m_q.size() > 0) begin
            e_pop = 1; e_win_valid = 1; e_win = m_q[0];
        end
        e_raw = (chk_addr_a != 0 && m_pend[chk_addr_a]) || (chk_addr_b != 0 && m_pend[chk_addr_b]);
    endfunction

    function automatic void model_seq();
        wb_req_t req;
        if (m_rf_we) begin
            m_regs[m_rf_addr] = m_rf_data;
            if (m_rf_from_q) m_pend[m_rf_addr] = 0;
        end
        if (sb_set && sb_set_addr != 0) m_pend[sb_set_addr] = 1;
        if (m_q.size() > 0 && !e_pop) begin
            m_lose++;
            if (m_lose == LIMIT) m_force = 1;
        end
        if (e_pop) begin
            void'(m_q.pop_front());
            m_lose = 0; m_force = 0;
        end
        if (wb1_valid && e_wb1_ready) begin
            req.addr = wb1_addr; req.data = wb1_data;
            m_q.push_back(req);
        end
        m_rf_we = e_win_valid && (e_win.addr != 0);
        if (m_rf_we) begin
            m_rf_addr = e_win.addr; m_rf_data = e_win.data;
        end
        m_rf_from_q = e_pop;
    endfunction

    task automatic tick();
        model_comb();
        @(posedge clk);
        model_seq();
        #1;
    endtask

    task automatic idle_inputs();
        wb0_valid = 0; wb0_addr = '0; wb0_data = '0;
        wb1_valid = 0; wb1_addr = '0; wb1_data = '0;
        sb_set = 0; sb_set_addr = '0; chk_addr_a = '0; chk_addr_b = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        chk_addr_a = 5'd3; chk_addr_b = 5'd17;
        #2;
        n_checks++; if (rf_we !== 1'b0)     begin n_fail++; $display("FAIL reset_rf_we got=%0h exp=0", rf_we); end
        n_checks++; if (rf_addr !== '0)     begin n_fail++; $display("FAIL reset_rf_addr got=%0h exp=0", rf_addr); end
        n_checks++; if (rf_data !== '0)     begin n_fail++; $display("FAIL reset_rf_data got=%0h exp=0", rf_data); end
        n_checks++; if (wb1_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wb1_ready got=%0h exp=1", wb1_ready); end
        n_checks++; if (wb0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wb0_ready got=%0h exp=0", wb0_ready); end
        n_checks++; if (raw_stall !== 1'b0) begin n_fail++; $display("FAIL reset_raw_stall got=%0h exp=0", raw_stall); end
        tick();
        idle_inputs();
    endtask

    task automatic test_single_wb0();
        wb0_valid = 1; wb0_addr = 5'd5; wb0_data = 32'h11;
        #2;
        n_checks++; if (wb0_ready !== 1'b1) begin n_fail++; $display("FAIL single_wb0_ready got=%0h exp=1", wb0_ready); end
        tick();
        idle_inputs();
        n_checks++; if (rf_we !== 1'b1)       begin n_fail++; $display("FAIL single_rf_we got=%0h exp=1", rf_we); end
        n_checks++; if (rf_addr !== 5'd5)     begin n_fail++; $display("FAIL single_rf_addr got=%0h exp=5", rf_addr); end
        n_checks++; if (rf_data !== 32'h11)   begin n_fail++; $display("FAIL single_rf_data got=%0h exp=11", rf_data); end
        tick();
        n_checks++; if (rf_we !== 1'b0)       begin n_fail++; $display("FAIL single_idle_we got=%0h exp=0", rf_we); end
        n_checks++; if (rf_addr !== 5'd5)     begin n_fail++; $display("FAIL single_hold_addr got=%0h exp=5", rf_addr); end
    endtask

    task automatic test_starvation();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            wb0_valid = 1; wb0_addr = 5'd3; wb0_data = DATA_W'(i);
            wb1_valid = (i == 0); wb1_addr = 5'd7; wb1_data = 32'hAB;
            #2;
            n_checks++;
            if (wb0_ready !== (i != 5)) begin n_fail++; $display("FAIL starve_wb0_ready cyc=%0d got=%0h exp=%0h", i, wb0_ready, (i != 5)); end
            tick();
            if (i == 5) begin
                n_checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd7 || rf_data !== 32'hAB)
                    begin n_fail++; $display("FAIL starve_forced_commit got we=%0h a=%0h d=%0h exp we=1 a=7 d=ab", rf_we, rf_addr, rf_data); end
            end
            if (i == 6) begin
                n_checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd3 || rf_data !== 32'd6)
                    begin n_fail++; $display("FAIL starve_resume got we=%0h a=%0h d=%0h exp we=1 a=3 d=6", rf_we, rf_addr, rf_data); end
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_scoreboard();
        bit exp_raw [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            chk_addr_a = 5'd9;
            if (i == 0) begin sb_set = 1; sb_set_addr = 5'd9; end
            if (i == 1) begin wb1_valid = 1; wb1_addr = 5'd9; wb1_data = 32'h99; end
            if (i == 2) begin chk_addr_a = '0; chk_addr_b = 5'd9; end
            #2;
            n_checks++;
            if (raw_stall !== exp_raw[i]) begin n_fail++; $display("FAIL sb_raw_stall cyc=%0d got=%0h exp=%0h", i, raw_stall, exp_raw[i]); end
            tick();
            if (i == 2) begin
                n_checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd9 || rf_data !== 32'h99)
                    begin n_fail++; $display("FAIL sb_commit got we=%0h a=%0h d=%0h exp we=1 a=9 d=99", rf_we, rf_addr, rf_data); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        wb_req_t lst [3];
        wb_req_t obs [$];
        int      idx = 0;
        bit      acc;
        lst[0] = {5'd10, 32'hA0}; lst[1] = {5'd11, 32'hB1}; lst[2] = {5'd12, 32'hC2};
        apply_reset();
        for (int cyc = 0; cyc < 40; cyc++) begin
            wb0_valid = (cyc < 30); wb0_addr = 5'd2; wb0_data = DATA_W'(cyc);
            wb1_valid = (idx < 3);
            if (idx < 3) begin wb1_addr = lst[idx].addr; wb1_data = lst[idx].data; end
            #2;
            if (cyc == 2) begin
                n_checks++; if (wb1_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready got=%0h exp=0", wb1_ready); end
            end
            acc = wb1_valid && wb1_ready;
            tick();
            if (acc) idx++;
            if (rf_we && rf_addr >= 5'd10) obs.push_back({rf_addr, rf_data});
        end
        idle_inputs();
        n_checks++; if (idx !== 3)        begin n_fail++; $display("FAIL b2b_accepted got=%0d exp=3", idx); end
        n_checks++; if (obs.size() !== 3) begin n_fail++; $display("FAIL b2b_commits got=%0d exp=3", obs.size()); end
        for (int k = 0; k < 3 && k < obs.size(); k++) begin
            n_checks++;
            if (obs[k] !== lst[k]) begin n_fail++; $display("FAIL b2b_order k=%0d got a=%0h d=%0h exp a=%0h d=%0h", k, obs[k].addr, obs[k].data, lst[k].addr, lst[k].data); end
        end
    endtask

    task automatic test_r0();
        apply_reset();
        for (int i = 0; i < 14; i++) begin
            wb0_valid = 1; wb0_addr = '0; wb0_data = 32'hFF;
            wb1_valid = (i < 2); wb1_addr = '0; wb1_data = DATA_W'(i + 1);
            sb_set = (i == 0); sb_set_addr = '0;
            chk_addr_a = 5'd6; chk_addr_b = '0;
            #2;
            n_checks++; if (raw_stall !== 1'b0) begin n_fail++; $display("FAIL r0_raw_stall cyc=%0d got=%0h exp=0", i, raw_stall); end
            tick();
            n_checks++; if (rf_we !== 1'b0)     begin n_fail++; $display("FAIL r0_rf_we cyc=%0d got=%0h exp=0", i, rf_we); end
        end
        idle_inputs();
        repeat (3) tick();
    endtask

    task automatic test_ordering();
        apply_reset();
        wb0_valid = 1; wb0_addr = 5'd4; wb0_data = 32'h1;
        wb1_valid = 1; wb1_addr = 5'd4; wb1_data = 32'h2;
        tick();
        idle_inputs();
        repeat (3) tick();
        n_checks++; if (dut_regs[4] !== 32'h2) begin n_fail++; $display("FAIL order_final_r4 got=%0h exp=2", dut_regs[4]); end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            wb0_valid = 1; wb0_addr = 5'd1; wb0_data = DATA_W'(i);
            wb1_valid = 1; wb1_addr = 5'(9 + i); wb1_data = DATA_W'(32'h50 + i);
            sb_set = 1; sb_set_addr = 5'(9 + i);
            tick();
        end
        idle_inputs();
        wb0_valid = 1; wb0_addr = 5'd1; chk_addr_a = 5'd9;
        #2;
        n_checks++; if (wb1_ready !== 1'b0) begin n_fail++; $display("FAIL mid_pre_full got=%0h exp=0", wb1_ready); end
        n_checks++; if (rf_we !== 1'b1)     begin n_fail++; $display("FAIL mid_pre_we got=%0h exp=1", rf_we); end
        n_checks++; if (raw_stall !== 1'b1) begin n_fail++; $display("FAIL mid_pre_raw got=%0h exp=1", raw_stall); end
        reset = 1'b1;
        #1;
        n_checks++; if (rf_we !== 1'b0)     begin n_fail++; $display("FAIL mid_rst_we got=%0h exp=0", rf_we); end
        n_checks++; if (wb1_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_wb1_ready got=%0h exp=1", wb1_ready); end
        n_checks++; if (raw_stall !== 1'b0) begin n_fail++; $display("FAIL mid_rst_raw got=%0h exp=0", raw_stall); end
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        idle_inputs();
        chk_addr_b = 5'd10;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (rf_we !== 1'b0 || raw_stall !== 1'b0)
                begin n_fail++; $display("FAIL mid_post_idle cyc=%0d got we=%0h raw=%0h exp 0 0", i, rf_we, raw_stall); end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            wb0_valid   = ($urandom_range(0, 9) < 6);
            wb0_addr    = ADDR_W'($urandom_range(0, 7));
            wb0_data    = $urandom;
            wb1_valid   = ($urandom_range(0, 9) < 4);
            wb1_addr    = ADDR_W'($urandom_range(0, 7));
            wb1_data    = $urandom;
            sb_set      = ($urandom_range(0, 3) == 0);
            sb_set_addr = ADDR_W'($urandom_range(0, 7));
            chk_addr_a  = ADDR_W'($urandom_range(0, 7));
            chk_addr_b  = ADDR_W'($urandom_range(0, 7));
            #2;
            model_comb();
            n_checks++; if (wb0_ready !== e_wb0_ready) begin n_fail++; $display("FAIL rnd_wb0_ready cyc=%0d got=%0h exp=%0h", cyc, wb0_ready, e_wb0_ready); end
            n_checks++; if (wb1_ready !== e_wb1_ready) begin n_fail++; $display("FAIL rnd_wb1_ready cyc=%0d got=%0h exp=%0h", cyc, wb1_ready, e_wb1_ready); end
            n_checks++; if (raw_stall !== e_raw)       begin n_fail++; $display("FAIL rnd_raw_stall cyc=%0d got=%0h exp=%0h", cyc, raw_stall, e_raw); end
            tick();
            n_checks++; if (rf_we !== m_rf_we) begin n_fail++; $display("FAIL rnd_rf_we cyc=%0d got=%0h exp=%0h", cyc, rf_we, m_rf_we); end
            if (m_rf_we) begin
                n_checks++;
                if (rf_addr !== m_rf_addr || rf_data !== m_rf_data)
                    begin n_fail++; $display("FAIL rnd_rf_write cyc=%0d got a=%0h d=%0h exp a=%0h d=%0h", cyc, rf_addr, rf_data, m_rf_addr, m_rf_data); end
            end
        end
        idle_inputs();
        repeat (6) tick();
        for (int r = 0; r < NREG; r++) begin
            n_checks++;
            if (dut_regs[r] !== m_regs[r]) begin n_fail++; $display("FAIL rnd_regfile r%0d got=%0h exp=%0h", r, dut_regs[r], m_regs[r]); end
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        model_reset();
        foreach (dut_regs[i]) dut_regs[i] = '0;
        foreach (m_regs[i]) m_regs[i] = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_wb0();
        test_starvation();
        test_scoreboard();
        test_back_to_back();
        test_r0();
        test_ordering();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
